des_stream_manager: RTL and testbench
=====================================

Name: des_stream_manager

Overview:
- Streams a byte-wide image memory through a 64-bit DES engine block by block, in either encrypt or decrypt mode.
- Reads 8 bytes, packs them into one 64-bit block, hands the block and the key to an external DES engine over a start/done handshake, then unpacks the result and writes 8 bytes to an output memory.
- Generalised successor of the image decrypter: parametrised address width, image length and base addresses; runtime mode select; optional CBC chaining.
- Sits between the image BRAMs and the DES core in the VGA pipeline.

Parameters:
- ADDR_W, 15: width of memory address ports.
- NUM_BYTES, 19200: bytes processed per run; must be a nonzero multiple of 8 (elaboration-time check, $error otherwise).
- RD_BASE, 0: first read address.
- WR_BASE, 0: first write address.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse begins a run; ignored while busy.
- mode  in  1  1 = encrypt, 0 = decrypt; latched at start.
- key  in  64  DES key; latched at start.
- iv  in  64  initial chaining value; latched at start; used only with CBC_EN.
- mem_rd_addr  out  ADDR_W  source byte address.
- mem_rd_data  in  8  source byte; valid one cycle after its address.
- mem_wr_addr  out  ADDR_W  destination byte address.
- mem_wr_data  out  8  destination byte.
- mem_wr_en  out  1  write strobe.
- eng_start  out  1  one-cycle request to the engine.
- eng_mode  out  1  latched mode.
- eng_key  out  64  latched key.
- eng_in  out  64  block presented to the engine; held stable from eng_start until eng_done.
- eng_done  in  1  engine result valid, one-cycle pulse.
- eng_out  in  64  engine result, valid with eng_done.
- busy  out  1  high from the cycle after an accepted start until done rises.
- done  out  1  rises the cycle after the final write; stays high until the next accepted start.

Behaviour:
- Reset values: all outputs 0 and state IDLE. Reset mid-run aborts immediately; no further writes occur, and done = 0.
- States and transitions:
  - IDLE: on start, latch mode/key/iv, clear the byte offset and done, go to RD.
  - RD, 8 cycles: mem_rd_addr = RD_BASE + off + k for k = 0..7. Data from the previous cycle is captured.
  - RD_LAST, 1 cycle: captures byte 7.
  - ENG_REQ, 1 cycle: eng_start = 1.
  - ENG_WAIT: stays until eng_done; latches eng_out in that cycle.
  - WR, 8 cycles: mem_wr_en = 1, mem_wr_addr = WR_BASE + off + k, mem_wr_data = result[8k+:8].
  - After WR: off += 8. If off == NUM_BYTES, go to IDLE and set done; otherwise go to RD.
- Packing: byte at offset k of a block occupies block bits [8k+7:8k] (byte 0 is the LSB). Unpacking uses the same mapping.
- Per-block cycle count = 18 + L, where L is the number of cycles spent in ENG_WAIT including the eng_done cycle.
- Boundaries:
  - eng_done outside ENG_WAIT is ignored.
  - start while busy is ignored; latched values are unchanged.
  - start in the same cycle done would rise: the run completes first and the start is ignored.
  - Address arithmetic is modulo 2^ADDR_W (wrap-around).
  - An offset counter of width ceil(log2(NUM_BYTES + 1)) bits suffices.

Optional Feature:
- Macro: DES_STREAM_CBC_EN. A 64-bit chain register is loaded with iv at start.
- Encrypt with CBC: eng_in = block ^ chain; chain <= eng_out; written data = eng_out.
- Decrypt with CBC: eng_in = block; written data = eng_out ^ chain; chain <= block (the ciphertext).
- Without the macro: ECB mode; iv is ignored and no chain register exists.

Decomposition:
- Shared package des_pkg holds:
  - BLOCK_BYTES = 8 and BLOCK_W = 64;
  - MODE_ENC = 1'b1 and MODE_DEC = 1'b0;
  - the state enum {IDLE, RD, RD_LAST, ENG_REQ, ENG_WAIT, WR}.
- One sub-module, des_block_buffer: 64-bit register with byte-lane load at index k and byte-lane select for output; shared by the pack and unpack paths.

Test Plan:
- ECB encrypt, NUM_BYTES = 16, with a mock engine (eng_out = eng_in ^ eng_key, L = 5) and key = 64'h133457799BBCDFF1 -> exactly 16 writes, each byte = src ^ key byte; done rises 46 cycles after start.
- Real DES engine, decrypt, key = 64'h133457799BBCDFF1, source block 64'h85E813540F0AB405 -> written block 64'h0123456789ABCDEF.
- start pulsed mid-run with a different key -> ignored: output matches the first key and busy is unbroken.
- reset_n driven low during the 3rd WR cycle of block 2 -> mem_wr_en drops asynchronously, no further writes, done = 0; a subsequent start reruns from RD_BASE.
- RD_BASE = 32760, ADDR_W = 15, NUM_BYTES = 16 -> read addresses wrap 32767 -> 0.
- DES_STREAM_CBC_EN defined, mock engine, iv = 64'hFFFF0000FFFF0000 -> block 0 eng_in = src0 ^ iv; block 1 eng_in = src1 ^ eng_out0; an encrypt-then-decrypt round trip restores the source.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants and state encodings for the DES stream manager.
package des_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BLOCK_BYTES = 8;
    localparam int unsigned BLOCK_W     = 64;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned STATE_W     = 3;

    localparam logic MODE_ENC = 1'b1;
    localparam logic MODE_DEC = 1'b0;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t RD       = 3'd1;
    localparam state_t RD_LAST  = 3'd2;
    localparam state_t ENG_REQ  = 3'd3;
    localparam state_t ENG_WAIT = 3'd4;
    localparam state_t WR       = 3'd5;

endpackage

// File: rtl/des_block_buffer.sv
// 64-bit block register: byte-lane load for packing, whole-block load for results,
// byte-lane select for unpacking.
module des_block_buffer
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               byte_we_i,
    input  logic [IDX_W-1:0]   byte_idx_i,
    input  logic [BYTE_W-1:0]  byte_i,
    input  logic               blk_we_i,
    input  logic [BLOCK_W-1:0] blk_i,
    input  logic [IDX_W-1:0]   sel_idx_i,
    output logic [BLOCK_W-1:0] blk_o,
    output logic [BYTE_W-1:0]  sel_byte_c
);

    logic [BLOCK_W-1:0] blk_q, blk_d;

    always_comb begin
        blk_d = blk_q;
        if (blk_we_i) begin
            blk_d = blk_i;
        end else if (byte_we_i) begin
            blk_d[{byte_idx_i, 3'b000} +: BYTE_W] = byte_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign blk_o      = blk_q;
    assign sel_byte_c = blk_q[{sel_idx_i, 3'b000} +: BYTE_W];

endmodule

// File: rtl/des_stream_manager.sv
// Streams a byte memory through an external DES engine, 8 bytes per block (ECB by default).
// Define DES_STREAM_CBC_EN to chain blocks in CBC mode, seeded from iv.
module des_stream_manager
    import des_pkg::*;
#(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned NUM_BYTES = 19200,
    parameter int unsigned RD_BASE   = 0,
    parameter int unsigned WR_BASE   = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               mode,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] iv,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [BYTE_W-1:0]  mem_rd_data,
    output logic [ADDR_W-1:0]  mem_wr_addr,
    output logic [BYTE_W-1:0]  mem_wr_data,
    output logic               mem_wr_en,
    output logic               eng_start,
    output logic               eng_mode,
    output logic [BLOCK_W-1:0] eng_key,
    output logic [BLOCK_W-1:0] eng_in,
    input  logic               eng_done,
    input  logic [BLOCK_W-1:0] eng_out,
    output logic               busy,
    output logic               done
);

    localparam int unsigned OFF_W = $clog2(NUM_BYTES + 1);

    if ((NUM_BYTES == 0) || ((NUM_BYTES % BLOCK_BYTES) != 0)) begin : g_bad_num_bytes
        $error("des_stream_manager: NUM_BYTES must be a nonzero multiple of 8");
    end

    state_t             state_q, state_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0]  wr_data_q, wr_data_d;
    logic               wr_en_q, wr_en_d;
    logic               eng_start_q, eng_start_d;
    logic               mode_q, mode_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] eng_in_q, eng_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               buf_byte_we_c, buf_blk_we_c;
    logic [IDX_W-1:0]   buf_idx_c, sel_idx_c;
    logic [BLOCK_W-1:0] blk_c, packed_c, eng_blk_c, result_c;
    logic [BYTE_W-1:0]  sel_byte_c;

    des_block_buffer u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_we_i  (buf_byte_we_c),
        .byte_idx_i (buf_idx_c),
        .byte_i     (mem_rd_data),
        .blk_we_i   (buf_blk_we_c),
        .blk_i      (result_c),
        .sel_idx_i  (sel_idx_c),
        .blk_o      (blk_c),
        .sel_byte_c (sel_byte_c)
    );

    // Byte 7 arrives in RD_LAST, so the engine block is formed straight from the read bus.
    assign packed_c = {mem_rd_data, blk_c[BLOCK_W-BYTE_W-1:0]};

`ifdef DES_STREAM_CBC_EN
    logic [BLOCK_W-1:0] chain_q, chain_d;
    logic               enc_c;

    assign enc_c     = (mode_q == MODE_ENC);
    assign eng_blk_c = enc_c ? (packed_c ^ chain_q) : packed_c;
    assign result_c  = enc_c ? eng_out : (eng_out ^ chain_q);

    // Chain carries the previous ciphertext: engine output when encrypting, engine input when decrypting.
    always_comb begin
        chain_d = chain_q;
        if ((state_q == IDLE) && start) begin
            chain_d = iv;
        end else if ((state_q == ENG_WAIT) && eng_done) begin
            chain_d = enc_c ? eng_out : eng_in_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end
`else
    logic unused_iv_c;

    assign eng_blk_c   = packed_c;
    assign result_c    = eng_out;
    assign unused_iv_c = ^iv;
`endif

    always_comb begin
        state_d       = state_q;
        off_d         = off_q;
        k_d           = k_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        mode_d        = mode_q;
        key_d         = key_q;
        eng_in_d      = eng_in_q;
        done_d        = done_q;
        buf_byte_we_c = 1'b0;
        buf_blk_we_c  = 1'b0;
        buf_idx_c     = k_q - IDX_W'(1);
        sel_idx_c     = k_q + IDX_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    key_d   = key;
                    off_d   = '0;
                    k_d     = '0;
                    done_d  = 1'b0;
                    state_d = RD;
                end
            end
            RD: begin
                buf_byte_we_c = (k_q != '0);
                if (k_q == IDX_W'(BLOCK_BYTES - 1)) begin
                    k_d     = '0;
                    state_d = RD_LAST;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            RD_LAST: begin
                buf_byte_we_c = 1'b1;
                buf_idx_c     = IDX_W'(BLOCK_BYTES - 1);
                eng_in_d      = eng_blk_c;
                state_d       = ENG_REQ;
            end
            ENG_REQ: begin
                state_d = ENG_WAIT;
            end
            ENG_WAIT: begin
                if (eng_done) begin
                    buf_blk_we_c = 1'b1;
                    wr_data_d    = result_c[BYTE_W-1:0];
                    k_d          = '0;
                    state_d      = WR;
                end
            end
            WR: begin
                if (k_q == IDX_W'(BLOCK_BYTES - 1)) begin
                    k_d   = '0;
                    off_d = off_q + OFF_W'(BLOCK_BYTES);
                    if (off_d == OFF_W'(NUM_BYTES)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end else begin
                    k_d       = k_q + IDX_W'(1);
                    wr_data_d = sel_byte_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Addresses wrap naturally at ADDR_W bits.
        if (state_d == RD) begin
            rd_addr_d = ADDR_W'(RD_BASE) + ADDR_W'(off_d) + ADDR_W'(k_d);
        end
        if (state_d == WR) begin
            wr_addr_d = ADDR_W'(WR_BASE) + ADDR_W'(off_d) + ADDR_W'(k_d);
        end
        wr_en_d     = (state_d == WR);
        eng_start_d = (state_d == ENG_REQ);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            off_q       <= '0;
            k_q         <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            eng_start_q <= 1'b0;
            mode_q      <= 1'b0;
            key_q       <= '0;
            eng_in_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            k_q         <= k_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            eng_start_q <= eng_start_d;
            mode_q      <= mode_d;
            key_q       <= key_d;
            eng_in_q    <= eng_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign mem_rd_addr = rd_addr_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign mem_wr_en   = wr_en_q;
    assign eng_start   = eng_start_q;
    assign eng_mode    = mode_q;
    assign eng_key     = key_q;
    assign eng_in      = eng_in_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_des_stream_manager.sv
// Directed bench for des_stream_manager: mock XOR engine (latency 5) or a DES known-answer
// engine, byte memories, wrap-around read base. Expectations follow DES_STREAM_CBC_EN.
`timescale 1ns/1ps
module tb_des_stream_manager;

    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned RD_BASE   = 32760;
    localparam int unsigned WR_BASE   = 100;
    localparam int          ENG_LAT   = 5;
    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B  = 64'hA5A5A5A55A5A5A5A;
    localparam logic [63:0] IV_A   = 64'hFFFF0000FFFF0000;
    localparam logic [63:0] DES_CT = 64'h85E813540F0AB405;
    localparam logic [63:0] DES_PT = 64'h0123456789ABCDEF;

    logic              clk, reset_n, start, mode;
    logic [63:0]       key, iv;
    logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
    logic [7:0]        mem_rd_data, mem_wr_data, rd_next;
    logic              mem_wr_en, eng_start, eng_mode, eng_done, busy, done;
    logic [63:0]       eng_key, eng_in, eng_out;
    logic              eng_done_m, stray_done;
    int                eng_cnt;
    bit                eng_kind;

    logic [7:0]        src_mem [0:(1<<ADDR_W)-1];
    logic [7:0]        dst_mem [0:(1<<ADDR_W)-1];
    int                wr_count;
    logic [63:0]       eng_in_log [$];
    logic [ADDR_W-1:0] rd_log [$];
    logic [ADDR_W-1:0] last_rd;
    logic [63:0]       exp_in  [0:1];
    logic [63:0]       exp_out [0:1];
    int                n_chk, n_pass;

    des_stream_manager #(
        .ADDR_W(ADDR_W), .NUM_BYTES(NUM_BYTES), .RD_BASE(RD_BASE), .WR_BASE(WR_BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .key(key), .iv(iv),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .eng_start(eng_start), .eng_mode(eng_mode), .eng_key(eng_key), .eng_in(eng_in),
        .eng_done(eng_done), .eng_out(eng_out), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read source memory: data for an address appears the following cycle.
    always @(negedge clk) rd_next = src_mem[mem_rd_addr];
    always @(posedge clk) mem_rd_data <= rd_next;

    function automatic logic [63:0] eng_result(input logic [63:0] din, input logic [63:0] k,
                                               input logic m);
        if (!eng_kind) return din ^ k;
        if (!m && din == DES_CT && k == KEY_A) return DES_PT;
        if (m && din == DES_PT && k == KEY_A) return DES_CT;
        return 64'h0;
    endfunction

    // Engine: eng_done seen by the DUT in the 5th ENG_WAIT cycle.
    always @(negedge clk) begin
        eng_done_m = 1'b0;
        if (!reset_n) begin
            eng_cnt = 0;
        end else if (eng_start) begin
            eng_cnt = 1;
        end else if (eng_cnt == ENG_LAT) begin
            eng_cnt    = 0;
            eng_done_m = 1'b1;
            eng_out    = eng_result(eng_in, eng_key, eng_mode);
        end else if (eng_cnt != 0) begin
            eng_cnt++;
        end
    end
    assign eng_done = eng_done_m | stray_done;

    always @(negedge clk) begin
        if (mem_wr_en) begin
            dst_mem[mem_wr_addr] = mem_wr_data;
            wr_count++;
        end
        if (eng_start) eng_in_log.push_back(eng_in);
        if (mem_rd_addr != last_rd) begin
            rd_log.push_back(mem_rd_addr);
            last_rd = mem_rd_addr;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] src_blk(input int b);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = src_mem[ADDR_W'(RD_BASE + 8*b + j)];
        return r;
    endfunction

    function automatic logic [63:0] dst_blk(input int b);
        logic [63:0] r;
        for (int j = 0; j < 8; j++) r[8*j +: 8] = dst_mem[ADDR_W'(WR_BASE + 8*b + j)];
        return r;
    endfunction

    task automatic set_src_blk(input int b, input logic [63:0] v);
        for (int j = 0; j < 8; j++) src_mem[ADDR_W'(RD_BASE + 8*b + j)] = v[8*j +: 8];
    endtask

    // Expected engine inputs and written blocks for the XOR mock engine.
    task automatic model(input logic enc, input logic [63:0] k, input logic [63:0] v);
        logic [63:0] chain, p, e, r;
        chain = v;
        for (int b = 0; b < 2; b++) begin
            p = src_blk(b);
`ifdef DES_STREAM_CBC_EN
            if (enc) begin
                e = p ^ chain; r = e ^ k; chain = r;
            end else begin
                e = p; r = (e ^ k) ^ chain; chain = p;
            end
`else
            e = p; r = e ^ k;
            chain = enc ? r : p;
`endif
            exp_in[b]  = e;
            exp_out[b] = r;
        end
    endtask

    task automatic run_stream(input logic md, input logic [63:0] k, input logic [63:0] v,
                              input int inj_at, input int stray_at, input int rst_at,
                              output int cyc, output bit brk);
        @(posedge clk);
        wr_count = 0;
        eng_in_log.delete();
        rd_log.delete();
        last_rd = mem_rd_addr;
        @(negedge clk);
        start = 1'b1; mode = md; key = k; iv = v;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        brk = 1'b0;
        while (!done && cyc < 400) begin
            if (cyc == inj_at) begin
                start = 1'b1; key = KEY_B; mode = ~md; iv = ~v;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
            stray_done = (cyc == stray_at);
            if (!done && !busy) brk = 1'b1;
            if (cyc == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                chk("rst_wr_en_async_drop", 64'(mem_wr_en), 64'd0);
                chk("rst_writes_before", 64'(wr_count), 64'd11);
                chk("rst_done_low", 64'(done), 64'd0);
                break;
            end
        end
        stray_done = 1'b0;
        if (rst_at < 0) chk("run_completes", 64'(done), 64'd1);
    endtask

    initial begin
        int cyc;
        bit brk;
        logic [63:0] orig0, orig1;

        n_chk = 0; n_pass = 0; wr_count = 0;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; key = '0; iv = '0;
        stray_done = 1'b0; eng_kind = 1'b0; eng_out = '0; last_rd = '0;
        for (int i = 0; i < 16; i++) src_mem[ADDR_W'(RD_BASE + i)] = 8'(i * 17 + 3);

        repeat (2) @(negedge clk);
        chk("reset_wr_en", 64'(mem_wr_en), 64'd0);
        chk("reset_eng_start", 64'(eng_start), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("reset_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("reset_wr_data", 64'(mem_wr_data), 64'd0);
        chk("reset_eng_in", eng_in, 64'd0);
        chk("reset_eng_key", eng_key, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Encrypt with a stray eng_done in RD and a rejected start (other key) mid-run.
        model(1'b1, KEY_A, IV_A);
        run_stream(1'b1, KEY_A, IV_A, 10, 3, -1, cyc, brk);
        chk("enc_cycles_to_done", 64'(cyc), 64'd46);
        chk("enc_write_count", 64'(wr_count), 64'd16);
        chk("enc_busy_unbroken", 64'(brk), 64'd0);
        chk("enc_key_latched", eng_key, KEY_A);
        chk("enc_mode_latched", 64'(eng_mode), 64'd1);
        chk("enc_eng_in_blk0", eng_in_log[0], exp_in[0]);
        chk("enc_eng_in_blk1", eng_in_log[1], exp_in[1]);
        chk("enc_out_blk0", dst_blk(0), exp_out[0]);
        chk("enc_out_blk1", dst_blk(1), exp_out[1]);
        chk("rd_addr_count", 64'(rd_log.size()), 64'd16);
        chk("rd_addr_first", 64'(rd_log[0]), 64'd32760);
        chk("rd_addr_pre_wrap", 64'(rd_log[7]), 64'd32767);
        chk("rd_addr_wrapped", 64'(rd_log[8]), 64'd0);
        repeat (3) @(negedge clk);
        chk("done_held", 64'(done), 64'd1);
        chk("idle_not_busy", 64'(busy), 64'd0);

        // Decrypt with start arriving in the cycle done rises.
        model(1'b0, KEY_A, IV_A);
        run_stream(1'b0, KEY_A, IV_A, 45, -1, -1, cyc, brk);
        chk("dec_cycles_to_done", 64'(cyc), 64'd46);
        chk("dec_out_blk0", dst_blk(0), exp_out[0]);
        chk("dec_out_blk1", dst_blk(1), exp_out[1]);
        @(negedge clk);
        chk("late_start_done_kept", 64'(done), 64'd1);
        chk("late_start_not_busy", 64'(busy), 64'd0);
        chk("late_start_key_kept", eng_key, KEY_A);

        // DES known-answer vector through the decrypt path.
        eng_kind = 1'b1;
        set_src_blk(0, DES_CT);
        set_src_blk(1, DES_CT);
        run_stream(1'b0, KEY_A, 64'd0, -1, -1, -1, cyc, brk);
        chk("des_kat_eng_in", eng_in_log[0], DES_CT);
        chk("des_kat_out_blk0", dst_blk(0), DES_PT);
        eng_kind = 1'b0;

        // Reset during the 3rd WR cycle of block 2, then a clean rerun.
        for (int i = 0; i < 16; i++) src_mem[ADDR_W'(RD_BASE + i)] = 8'(i * 29 + 7);
        run_stream(1'b1, KEY_A, IV_A, -1, -1, 40, cyc, brk);
        repeat (3) @(negedge clk);
        chk("rst_held_no_writes", 64'(wr_count), 64'd11);
        chk("rst_held_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_released_no_writes", 64'(wr_count), 64'd11);
        chk("rst_released_done", 64'(done), 64'd0);
        model(1'b1, KEY_A, IV_A);
        run_stream(1'b1, KEY_A, IV_A, -1, -1, -1, cyc, brk);
        chk("rerun_cycles", 64'(cyc), 64'd46);
        chk("rerun_rd_first", 64'(rd_log[0]), 64'd32760);
        chk("rerun_out_blk0", dst_blk(0), exp_out[0]);
        chk("rerun_out_blk1", dst_blk(1), exp_out[1]);

        // Encrypt then decrypt the result; the source must come back.
        orig0 = src_blk(0);
        orig1 = src_blk(1);
        run_stream(1'b1, KEY_B, IV_A, -1, -1, -1, cyc, brk);
        set_src_blk(0, dst_blk(0));
        set_src_blk(1, dst_blk(1));
        run_stream(1'b0, KEY_B, IV_A, -1, -1, -1, cyc, brk);
        chk("roundtrip_blk0", dst_blk(0), orig0);
        chk("roundtrip_blk1", dst_blk(1), orig1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
